// File: rtl/ibex_instr_wb_bridge_if.sv
// ibex_instr_wb_bridge_if: fetch-side request/response and Wishbone master signals of the bridge
interface ibex_instr_wb_bridge_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  modport master (
    input  instr_req_i, instr_addr_i, wb_dat_i, wb_ack_i, wb_err_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o
  );
  modport slave (
    output instr_req_i, instr_addr_i, wb_dat_i, wb_ack_i, wb_err_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o
  );
endinterface

// File: rtl/ibex_instr_wb_bridge.sv
// ibex_instr_wb_bridge: instruction fetch req/gnt/rvalid to classic Wishbone read, one transfer in flight.
// Optional bus timeout enabled by defining IBEX_INSTR_WB_TIMEOUT_EN.
module ibex_instr_wb_bridge #(
  parameter int unsigned TimeoutCycles = 255,
  parameter bit          ResetAll      = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  ibex_instr_wb_bridge_if.master bus,
  output logic                   busy_o
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        gnt, timeout;
`ifdef IBEX_INSTR_WB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  assign cnt_d   = (state_q == BUS) ? cnt_q + 1'b1 : '0;
  // fires in the last allowed BUS cycle so the transfer occupies exactly TimeoutCycles cycles
  assign timeout = (state_q == BUS) && (cnt_q == CntW'(TimeoutCycles - 1));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gnt     = 1'b0;
    case (state_q)
      BUS: begin
        if (bus.wb_ack_i || bus.wb_err_i) begin
          state_d = RESP;
          rdata_d = bus.wb_err_i ? '0 : bus.wb_dat_i;
          err_d   = bus.wb_err_i;
        end else if (timeout) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      default: begin
        gnt     = bus.instr_req_i;
        state_d = bus.instr_req_i ? BUS : IDLE;
        addr_d  = bus.instr_req_i ? {bus.instr_addr_i[31:2], 2'b00} : addr_q;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end
  if (ResetAll) begin : g_data_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        addr_q  <= '0;
        rdata_q <= '0;
      end else begin
        addr_q  <= addr_d;
        rdata_q <= rdata_d;
      end
    end
  end else begin : g_data_nrst
    always_ff @(posedge clk_i) begin
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.instr_gnt_o    = gnt;
  assign bus.instr_rvalid_o = state_q == RESP;
  assign bus.instr_rdata_o  = rdata_q;
  assign bus.instr_err_o    = err_q;
  assign bus.wb_cyc_o       = state_q == BUS;
  assign bus.wb_stb_o       = state_q == BUS;
  assign bus.wb_we_o        = 1'b0;
  assign bus.wb_sel_o       = 4'hF;
  assign bus.wb_adr_o       = addr_q;
  assign busy_o             = state_q != IDLE;
endmodule

// File: tb/tb_ibex_instr_wb_bridge.sv
// tb_ibex_instr_wb_bridge: directed scenarios plus randomized traffic against an address-keyed memory model.
module tb_ibex_instr_wb_bridge;
  logic clk, rst_n, busy;
  int   errors = 0, checks = 0;
  ibex_instr_wb_bridge_if bus ();
  ibex_instr_wb_bridge #(.TimeoutCycles(4)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus), .busy_o(busy));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] data_of(logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction
  function automatic logic err_of(logic [31:0] a);
    return a[4:2] == 3'd5;
  endfunction
  task automatic test_reset;
    @(negedge clk); #1;
    checks++; if ({bus.instr_gnt_o, bus.instr_rvalid_o, bus.instr_err_o, bus.wb_cyc_o, bus.wb_stb_o, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 000000", {bus.instr_gnt_o, bus.instr_rvalid_o, bus.instr_err_o, bus.wb_cyc_o, bus.wb_stb_o, busy}); end
    checks++; if ({bus.wb_we_o, bus.wb_sel_o} !== 5'b0_1111) begin
      errors++; $display("FAIL reset_we_sel: got %b exp 01111", {bus.wb_we_o, bus.wb_sel_o}); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b exp 0", busy); end
  endtask
  task automatic test_single;
    @(negedge clk); bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h1000_0006; #1;
    checks++; if (bus.instr_gnt_o !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b exp 1", bus.instr_gnt_o); end
    @(negedge clk); bus.instr_req_i = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hDEAD_BEEF; #1;
    checks++; if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, busy} !== 8'b1101_1111) begin
      errors++; $display("FAIL single_bus_ctrl: got %b exp 11011111", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, busy}); end
    checks++; if (bus.wb_adr_o !== 32'h1000_0004) begin errors++; $display("FAIL single_adr: got %h exp 10000004", bus.wb_adr_o); end
    @(negedge clk); bus.wb_ack_i = 1'b0; #1;
    checks++; if ({bus.instr_rvalid_o, bus.instr_err_o, bus.wb_cyc_o, bus.instr_rdata_o} !== {3'b100, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL single_resp: got rv=%b err=%b cyc=%b data=%h exp 1 0 0 deadbeef", bus.instr_rvalid_o, bus.instr_err_o, bus.wb_cyc_o, bus.instr_rdata_o); end
    @(negedge clk); #1;
    checks++; if ({bus.instr_rvalid_o, busy, bus.instr_rdata_o} !== {2'b00, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL single_after: got rv=%b busy=%b data=%h exp 0 0 deadbeef", bus.instr_rvalid_o, busy, bus.instr_rdata_o); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] a [3] = '{32'h100, 32'h104, 32'h108};
    logic [31:0] d [3];
    int n = 0, last_rv = 0;
    foreach (d[i]) d[i] = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); n++; bus.instr_req_i = 1'b1; bus.instr_addr_i = a[i]; #1;
      checks++; if (bus.instr_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d: got %b exp 1", i, bus.instr_gnt_o); end
      if (i > 0) begin
        checks++; if ({bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o} !== {2'b10, d[i-1]}) begin
          errors++; $display("FAIL b2b_resp%0d: got rv=%b err=%b data=%h exp 1 0 %h", i-1, bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o, d[i-1]); end
        if (i > 1) begin
          checks++; if (n - last_rv !== 4) begin errors++; $display("FAIL b2b_spacing%0d: got %0d exp 4", i-1, n - last_rv); end
        end
        last_rv = n;
      end
      for (int w = 0; w < 3; w++) begin
        @(negedge clk); n++; bus.instr_addr_i = $urandom; bus.wb_ack_i = (w == 2); bus.wb_dat_i = (w == 2) ? d[i] : $urandom; #1;
        checks++; if ({bus.wb_cyc_o, bus.instr_gnt_o, bus.wb_adr_o} !== {2'b10, a[i]}) begin
          errors++; $display("FAIL b2b_bus%0d_%0d: got cyc=%b gnt=%b adr=%h exp 1 0 %h", i, w, bus.wb_cyc_o, bus.instr_gnt_o, bus.wb_adr_o, a[i]); end
      end
    end
    @(negedge clk); n++; bus.instr_req_i = 1'b0; bus.wb_ack_i = 1'b0; #1;
    checks++; if ({bus.instr_rvalid_o, bus.instr_rdata_o} !== {1'b1, d[2]} || n - last_rv !== 4) begin
      errors++; $display("FAIL b2b_last: got rv=%b data=%h gap=%0d exp 1 %h 4", bus.instr_rvalid_o, bus.instr_rdata_o, n - last_rv, d[2]); end
  endtask
  task automatic test_error;
    @(negedge clk); bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h200; #1;
    checks++; if (bus.instr_gnt_o !== 1'b1) begin errors++; $display("FAIL err_gnt: got %b exp 1", bus.instr_gnt_o); end
    @(negedge clk); bus.instr_req_i = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1; bus.wb_dat_i = 32'h5555_AAAA;
    @(negedge clk); bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h204; #1;
    checks++; if ({bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o, bus.instr_gnt_o} !== {2'b11, 32'h0, 1'b1}) begin
      errors++; $display("FAIL err_resp: got rv=%b err=%b data=%h gnt=%b exp 1 1 0 1", bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o, bus.instr_gnt_o); end
    @(negedge clk); bus.instr_req_i = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h1234_5678; #1;
    checks++; if ({bus.wb_cyc_o, bus.wb_adr_o} !== {1'b1, 32'h204}) begin
      errors++; $display("FAIL err_next_bus: got cyc=%b adr=%h exp 1 204", bus.wb_cyc_o, bus.wb_adr_o); end
    @(negedge clk); bus.wb_ack_i = 1'b0; #1;
    checks++; if ({bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o} !== {2'b10, 32'h1234_5678}) begin
      errors++; $display("FAIL err_next_resp: got rv=%b err=%b data=%h exp 1 0 12345678", bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o); end
  endtask
  task automatic test_spurious;
    @(negedge clk); bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hBAD0_BAD0;
    @(negedge clk); bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b1; #1;
    checks++; if ({bus.instr_rvalid_o, bus.wb_cyc_o, busy} !== 3'b000) begin
      errors++; $display("FAIL spur_ack: got rv/cyc/busy=%b exp 000", {bus.instr_rvalid_o, bus.wb_cyc_o, busy}); end
    @(negedge clk); bus.wb_err_i = 1'b0; bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h700; #1;
    checks++; if ({bus.instr_rvalid_o, bus.wb_cyc_o} !== 2'b00) begin
      errors++; $display("FAIL spur_err: got rv/cyc=%b exp 00", {bus.instr_rvalid_o, bus.wb_cyc_o}); end
    #1 bus.instr_req_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      checks++; if ({bus.instr_rvalid_o, bus.wb_cyc_o, busy} !== 3'b000) begin
        errors++; $display("FAIL spur_req_drop%0d: got rv/cyc/busy=%b exp 000", k, {bus.instr_rvalid_o, bus.wb_cyc_o, busy}); end
    end
  endtask
  task automatic test_reset_in_bus;
    @(negedge clk); bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h300;
    @(negedge clk); bus.instr_req_i = 1'b0; #1;
    checks++; if (bus.wb_cyc_o !== 1'b1) begin errors++; $display("FAIL rstbus_cyc_before: got %b exp 1", bus.wb_cyc_o); end
    #1 rst_n = 1'b0; #1;
    checks++; if ({bus.wb_cyc_o, bus.wb_stb_o, busy} !== 3'b000) begin
      errors++; $display("FAIL rstbus_async: got cyc/stb/busy=%b exp 000", {bus.wb_cyc_o, bus.wb_stb_o, busy}); end
    @(negedge clk); rst_n = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hFFFF_0000;
    @(negedge clk); bus.wb_ack_i = 1'b0; #1;
    checks++; if ({bus.instr_rvalid_o, bus.wb_cyc_o} !== 2'b00) begin
      errors++; $display("FAIL rstbus_no_rvalid: got rv/cyc=%b exp 00", {bus.instr_rvalid_o, bus.wb_cyc_o}); end
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h403; #1;
    checks++; if (bus.instr_gnt_o !== 1'b1) begin errors++; $display("FAIL rstbus_fresh_gnt: got %b exp 1", bus.instr_gnt_o); end
    @(negedge clk); bus.instr_req_i = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h00C0_FFEE; #1;
    checks++; if ({bus.wb_cyc_o, bus.wb_adr_o} !== {1'b1, 32'h400}) begin
      errors++; $display("FAIL rstbus_fresh_adr: got cyc=%b adr=%h exp 1 400", bus.wb_cyc_o, bus.wb_adr_o); end
    @(negedge clk); bus.wb_ack_i = 1'b0; #1;
    checks++; if ({bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o} !== {2'b10, 32'h00C0_FFEE}) begin
      errors++; $display("FAIL rstbus_fresh_resp: got rv=%b err=%b data=%h exp 1 0 00c0ffee", bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o); end
  endtask
  task automatic test_timeout;
    @(negedge clk); bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h500;
    @(negedge clk); bus.instr_req_i = 1'b0;
`ifdef IBEX_INSTR_WB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.wb_cyc_o !== 1'b1) begin errors++; $display("FAIL tmo_bus%0d: got cyc=%b exp 1", k, bus.wb_cyc_o); end
      @(negedge clk);
    end
    #1;
    checks++; if ({bus.wb_cyc_o, bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o} !== {3'b011, 32'h0}) begin
      errors++; $display("FAIL tmo_resp: got cyc=%b rv=%b err=%b data=%h exp 0 1 1 0", bus.wb_cyc_o, bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o); end
`else
    repeat (100) @(negedge clk);
    #1;
    checks++; if ({bus.wb_cyc_o, busy, bus.instr_rvalid_o} !== 3'b110) begin
      errors++; $display("FAIL tmo_off_wait: got cyc/busy/rv=%b exp 110", {bus.wb_cyc_o, busy, bus.instr_rvalid_o}); end
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h0BAD_F00D;
    @(negedge clk); bus.wb_ack_i = 1'b0; #1;
    checks++; if ({bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o} !== {2'b10, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL tmo_off_resp: got rv=%b err=%b data=%h exp 1 0 0badf00d", bus.instr_rvalid_o, bus.instr_err_o, bus.instr_rdata_o); end
`endif
    @(negedge clk);
  endtask
  task automatic test_random;
    logic [31:0] q [$];
    logic        inflight = 1'b0, exp_rv = 1'b0, g;
    logic [31:0] rv_addr = '0;
    int          waits = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
      checks++; if (bus.instr_rvalid_o !== exp_rv) begin errors++; $display("FAIL rnd_rvalid@%0d: got %b exp %b", c, bus.instr_rvalid_o, exp_rv); end
      if (exp_rv) begin
        checks++; if ({bus.instr_err_o, bus.instr_rdata_o} !== {err_of(rv_addr), err_of(rv_addr) ? 32'h0 : data_of(rv_addr)}) begin
          errors++; $display("FAIL rnd_data@%0d: got err=%b data=%h for addr %h", c, bus.instr_err_o, bus.instr_rdata_o, rv_addr); end
      end
      exp_rv = 1'b0;
      checks++; if (bus.wb_cyc_o !== inflight) begin errors++; $display("FAIL rnd_cyc@%0d: got %b exp %b", c, bus.wb_cyc_o, inflight); end
      if (inflight) begin
        checks++; if (bus.wb_adr_o !== q[0]) begin errors++; $display("FAIL rnd_adr@%0d: got %h exp %h", c, bus.wb_adr_o, q[0]); end
        if (waits == 0) begin
          rv_addr = q.pop_front();
          bus.wb_err_i = err_of(rv_addr);
          bus.wb_ack_i = err_of(rv_addr) ? 1'($urandom_range(0, 1)) : 1'b1;
          bus.wb_dat_i = data_of(rv_addr);
          exp_rv = 1'b1;
        end else begin
          waits--;
          bus.wb_dat_i = $urandom;
        end
      end else begin
        bus.wb_ack_i = ($urandom_range(0, 7) == 0);
        bus.wb_err_i = ($urandom_range(0, 7) == 0);
        bus.wb_dat_i = $urandom;
      end
      bus.instr_req_i  = ($urandom_range(0, 2) != 0);
      bus.instr_addr_i = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 255);
      #1;
      g = bus.instr_req_i && !inflight;
      checks++; if (bus.instr_gnt_o !== g) begin errors++; $display("FAIL rnd_gnt@%0d: got %b exp %b", c, bus.instr_gnt_o, g); end
      if (exp_rv) inflight = 1'b0;
      if (g) begin
        q.push_back({bus.instr_addr_i[31:2], 2'b00});
        inflight = 1'b1;
        waits = $urandom_range(0, 3);
      end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    bus.instr_req_i = 1'b0; bus.instr_addr_i = '0;
    bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_error();
    test_spurious();
    test_reset_in_bus();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ibex_instr_wb_bridge.md
Name: ibex_instr_wb_bridge

Overview:
- Bridges the core instruction-fetch request interface (req/gnt/rvalid) onto a classic Wishbone master port for the management SoC bus.
- Sits directly upstream of the prefetch buffer: it drives the buffer's instr_gnt/instr_rvalid/instr_rdata/instr_err inputs and consumes its instr_req/instr_addr outputs.
- Allows one bus transaction in flight. The prefetch buffer's tolerance of 1..2 outstanding requests is unaffected.

Parameters:
- TimeoutCycles, 255, number of BUS-state cycles without ack/err before a forced error termination (only used with IBEX_INSTR_WB_TIMEOUT_EN); legal 1..65535.
- ResetAll, 1'b0, when 1 the data/address registers are also reset to 0; otherwise only control state is reset.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous active-low reset (already decided)
- instr_req_i  in  1  fetch request from the prefetch buffer
- instr_addr_i  in  32  fetch address (bits [1:0] ignored)
- instr_gnt_o  out  1  request accepted this cycle
- instr_rvalid_o  out  1  response valid, one-cycle pulse
- instr_rdata_o  out  32  fetched word
- instr_err_o  out  1  bus error qualifier, valid with rvalid
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  constant 0
- wb_sel_o  out  4  constant 4'hF
- wb_adr_o  out  32  word-aligned address {addr[31:2],2'b00}
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  transfer acknowledge
- wb_err_i  in  1  transfer error
- busy_o  out  1  high when the state is not IDLE

Behaviour:
- Reset values: state=IDLE; instr_gnt_o=0, instr_rvalid_o=0, instr_err_o=0, wb_cyc_o=0, wb_stb_o=0, busy_o=0. instr_rdata_o and wb_adr_o are 0 if ResetAll, otherwise don't-care.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - instr_gnt_o = instr_req_i (combinational).
  - On gnt, latch {instr_addr_i[31:2],2'b00} into addr_q and go to BUS.
- BUS:
  - wb_cyc_o = wb_stb_o = 1, wb_adr_o = addr_q; instr_gnt_o = 0.
  - On wb_ack_i or wb_err_i: capture rdata_q <= wb_dat_i (0 on err) and err_q <= wb_err_i, then go to RESP.
  - ack and err in the same cycle: err wins, rdata_q = 0.
  - An ack in the first BUS cycle is legal, giving a minimum of 1 bus cycle.
- RESP:
  - instr_rvalid_o = 1 for exactly one cycle with rdata_q/err_q; cyc/stb low.
  - instr_gnt_o = instr_req_i. On gnt, latch the new address and go to BUS (back-to-back); otherwise go to IDLE.
- Latency: gnt at cycle N, stb at N+1, ack at N+1+k, rvalid at N+2+k. Zero-wait throughput is one fetch per 2 cycles.
- wb_ack_i/wb_err_i outside BUS are ignored: no state change, no rvalid.
- instr_rdata_o and instr_err_o hold their last value when rvalid=0; instr_err_o is only meaningful with rvalid.
- instr_addr_i is sampled only in the gnt cycle; later changes do not affect an in-flight transfer.
- A req_i drop without gnt is legal (speculative branch suppression) and causes no bus activity.
- Reset asserted mid-BUS: cyc/stb drop asynchronously, no rvalid is issued, state returns to IDLE.

Optional Feature:
- Macro IBEX_INSTR_WB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TimeoutCycles+1) clears on BUS entry and increments each BUS cycle without ack/err.
  - When it equals TimeoutCycles: drop cyc/stb, go to RESP with err_q=1, rdata_q=0.
  - An ack/err in the terminating cycle takes priority over the timeout.
- Undefined: no counter is present; BUS waits indefinitely for ack/err.

Test Plan:
- Single fetch: req with addr=0x1000_0006, zero-wait ack, dat=0xDEAD_BEEF -> wb_adr_o=0x1000_0004, sel=F, we=0; rvalid 2 cycles after gnt with rdata=0xDEADBEEF, err=0.
- Back-to-back: req held high for addr 0x100, 0x104, 0x108, ack after 2 wait states -> gnt in the RESP cycle, three rvalids spaced 4 cycles apart, correct data order.
- Error: wb_err_i=1 together with wb_ack_i=1 -> rvalid with err=1, rdata=0; the next fetch proceeds normally.
- Spurious/late strobes: ack pulsed while IDLE, and req dropped before gnt -> no rvalid, cyc stays 0.
- Reset in BUS: rst_ni low for 1 cycle while cyc=1 -> cyc=0 immediately; no rvalid after release; the next req starts a fresh transfer.
- Timeout (macro on, TimeoutCycles=4): no ack -> cyc drops after 4 BUS cycles, rvalid with err=1; with the macro off the bridge is still in BUS after 100 cycles.
